// File: rtl/mult_pkg.sv
// Shared types and decode constants for the iterative multiply unit.
// No logic here: states and funct encodings only.
// No flow control: consumed by the multiplier and by the decoder that drives Start/Signed.
package mult_pkg;

  // Controller states. Busy is asserted in RUN; Done is asserted in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // R-type funct field values the decoder uses to raise Start and select Signed.
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate: out = neg ? -in : in.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
module mult_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  // Negate by invert-plus-one. For the most-negative input the result is the
  // same bit pattern, which read as unsigned is exactly its magnitude.
  always_comb begin
    out_o = in_i;
    if (neg_i) begin
      out_o = ~in_i + W'(1);
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier (MULT/MULTU), one multiplier bit per clock.
// Latency: WIDTH edges from accept to result (fewer with MULT_EARLY_TERM_EN defined).
// Backpressure: Start is accepted only while Busy==0; Start while busy is dropped.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   DataA,
  input  logic [WIDTH-1:0]   DataB,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] DataOut
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  // Controller and datapath state.
  state_e           state_q, state_d;
  logic [PW-1:0]    mcnd_q,  mcnd_d;   // shifted magnitude of the multiplicand
  logic [WIDTH-1:0] mpy_q,   mpy_d;    // remaining multiplier bits, LSB first
  logic [PW-1:0]    prod_q,  prod_d;   // unsigned partial product
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // iterations completed
  logic             neg_q,   neg_d;    // result must be negated at the end
  logic [PW-1:0]    dout_q,  dout_d;   // last completed product

  // Operand magnitudes and the sign-corrected final product.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    prod_sum;
  logic [PW-1:0]    prod_fixed;
  logic             last_iter;
  logic             accept;

  mult_sign_fix #(.W(WIDTH)) u_fix_a (
    .in_i  (DataA),
    .neg_i (Signed & DataA[WIDTH-1]),
    .out_o (mag_a)
  );

  mult_sign_fix #(.W(WIDTH)) u_fix_b (
    .in_i  (DataB),
    .neg_i (Signed & DataB[WIDTH-1]),
    .out_o (mag_b)
  );

  mult_sign_fix #(.W(PW)) u_fix_p (
    .in_i  (prod_sum),
    .neg_i (neg_q),
    .out_o (prod_fixed)
  );

  // Partial product after this edge's add step.
  always_comb begin
    prod_sum = prod_q;
    if (mpy_q[0]) begin
      prod_sum = prod_q + mcnd_q;
    end
  end

  // Decide whether the current RUN edge is the last one.
`ifdef MULT_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this iteration.
  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mpy_q[WIDTH-1:1] == '0);
  end
`else
  // Fixed schedule: always WIDTH iterations.
  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end
`endif

  // Next-state and datapath control; a new request is taken in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    mcnd_d  = mcnd_q;
    mpy_d   = mpy_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dout_d  = dout_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = prod_sum;
        mcnd_d = mcnd_q << 1;
        mpy_d  = mpy_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) begin
          dout_d  = prod_fixed;
          state_d = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand capture shared by the IDLE and DONE accept paths.
    if (accept) begin
      mcnd_d = {{WIDTH{1'b0}}, mag_a};
      mpy_d  = mag_b;
      prod_d = '0;
      cnt_d  = '0;
      neg_d  = Signed & (DataA[WIDTH-1] ^ DataB[WIDTH-1]);
    end
  end

  // State register; reset aborts any operation in flight and clears the result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      mcnd_q  <= '0;
      mpy_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnd_q  <= mcnd_d;
      mpy_q   <= mpy_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dout_q  <= dout_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    Busy    = (state_q == RUN);
    Done    = (state_q == DONE);
    DataOut = dout_q;
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;
  import mult_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] DataA = '0;
  logic [31:0] DataB = '0;
  logic        Busy;
  logic        Done;
  logic [63:0] DataOut;

  seq_shift_add_mult #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Signed  (Signed),
    .DataA   (DataA),
    .DataB   (DataB),
    .Busy    (Busy),
    .Done    (Done),
    .DataOut (DataOut)
  );

  always #5 Clk = ~Clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          t;
    int          tdone;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_res = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sb_v;
    longint unsigned ua, ub;
    if (s) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      return 64'(sa * sb_v);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return 64'(ua * ub);
  endfunction

  // Edges from accept to result.
  function automatic int lat(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] mag;
    int          bl;
    mag = (s && b[31]) ? (32'd0 - b) : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
    return (bl < 1) ? 1 : bl;
`else
    return 32;
`endif
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Called just after an edge when the DUT will accept; returns the accept edge.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn, output int t);
    exp_t e;
    logic s;
    s = (fn == FN_MULT);
    DataA = a; DataB = b; Signed = s; Start = 1'b1;
    t = cyc + 1;
    e.prod = model(a, b, s);
    e.t = t;
    e.tdone = t + lat(b, s);
    sb.push_back(e);
    wait_edges(1);
    Start = 1'b0;
  endtask

  // Issue, wait into the Done cycle, then an optional gap.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn, input int gap);
    int t;
    drive_op(a, b, fn, t);
    wait_edges(lat(b, fn == FN_MULT));
    wait_edges(gap);
  endtask

  // Monitor: checks Busy, Done timing, result and result hold every cycle.
  always @(negedge Clk) begin
    exp_t e;
    logic busy_exp;
    if (!Reset) begin
      busy_exp = (sb.size() > 0) && (cyc >= sb[0].t) && (cyc < sb[0].tdone);
      chk("busy", 64'(Busy), 64'(busy_exp));
      if (Done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done cyc=%0d actual=1 expected=0", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.tdone));
          chk("product", DataOut, e.prod);
          last_res = e.prod;
        end
      end else if (sb.size() > 0 && cyc >= sb[0].tdone) begin
        checks++;
        failures++;
        $display("FAIL missing_done cyc=%0d actual=0 expected=1", cyc);
        void'(sb.pop_front());
      end else begin
        chk("dataout_hold", DataOut, last_res);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t;
    int bound;
    wait_edges(2);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_dataout", DataOut, 64'd0);
    #1;

    // Directed products.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_MULTU, 1);
    run_op(32'hFFFF_FFFD, 32'd7, FN_MULT, 0);
    run_op(32'h8000_0000, 32'h8000_0000, FN_MULT, 2);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, FN_MULT, 1);
    run_op(32'h0000_1234, 32'd1, FN_MULT, 1);
    run_op(32'h0000_1234, 32'd0, FN_MULTU, 1);
    run_op(32'd5, 32'hFFFF_FFFC, FN_MULT, 1);

    // Start mid-RUN is dropped; Start in the Done cycle is taken at once.
    drive_op(32'd5, 32'd6, FN_MULTU, t);
    DataA = 32'd9; DataB = 32'd9; Start = 1'b1;
    wait_edges(1);
    Start = 1'b0;
    wait_edges(lat(32'd6, 1'b0) - 1);
    run_op(32'd7, 32'd8, FN_MULTU, 2);

    // Reset after ten iterations aborts the operation.
    drive_op(32'h0000_DEAD, 32'h0000_BEEF, FN_MULTU, t);
    wait_edges(10);
    Reset = 1'b1;
    sb.delete();
    last_res = '0;
    wait_edges(1);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_dataout", DataOut, 64'd0);
    #1;
    run_op(32'd2, 32'd3, FN_MULTU, 1);

    // Start together with Reset does not begin an operation.
    Reset = 1'b1; Start = 1'b1; DataA = 32'd4; DataB = 32'd4; Signed = 1'b0;
    last_res = '0;
    wait_edges(1);
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("rststart_busy", 64'(Busy), 64'd0);
    chk("rststart_dataout", DataOut, 64'd0);
    #1;
    wait_edges(3);

    // Randomised operations with random gaps, including back-to-back.
    for (int i = 0; i < 40; i++) begin
      run_op(pick(), pick(), ($urandom_range(0, 1) == 1) ? FN_MULT : FN_MULTU, $urandom_range(0, 2));
    end

    bound = 0;
    while (sb.size() > 0 && bound < 100) begin
      wait_edges(1);
      bound++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    wait_edges(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
